// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch resolution plus IF-stage direction
// prediction from a table of 2-bit saturating counters (bimodal or gshare).
// Optional build macro: BPU_PERF_EN adds branch/mispredict event counters.
module branch_predict_unit #(
    parameter int IDX_W    = 6,
    parameter int GSHARE   = 0,
    parameter int CNT_INIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             ex_valid,
    input  logic [4:0]       ex_opcode,
    input  logic             ex_pred_taken,
    input  logic [IDX_W-1:0] ex_pred_idx,
    input  logic             alu_out0,
    output logic             is_branch,
    output logic             is_jalr,
    output logic [1:0]       inst_type,
    output logic             branch_taken,
    output logic             mispredict,
`ifdef BPU_PERF_EN
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispred,
`endif
    output logic [IDX_W-1:0] ghr
);

    localparam int unsigned DEPTH      = 2 ** IDX_W;
    localparam logic [4:0]  OP_BRANCH  = 5'b11000;
    localparam logic [4:0]  OP_JALR    = 5'b11001;
    localparam logic [1:0]  CNT_RST    = CNT_INIT[1:0];

    logic [1:0] cnt_tbl [DEPTH];
    logic [1:0] cnt_cur;
    logic [1:0] cnt_nxt;
    logic       upd;
    logic       unused_pc_bits;

    // Only the word-index bits of the fetch PC feed the lookup.
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // EX-side decode and resolution; mispredict is the only output gated by ex_valid.
    always_comb begin
        is_branch    = (ex_opcode == OP_BRANCH);
        is_jalr      = (ex_opcode == OP_JALR);
        inst_type    = {is_branch, is_jalr};
        branch_taken = alu_out0 & is_branch;
        mispredict   = ex_valid & is_branch & (branch_taken != ex_pred_taken);
        upd          = ex_valid & is_branch;
    end

    // IF-side lookup; the table read is not bypassed from a same-cycle update.
    always_comb begin
        pred_idx   = (GSHARE != 0) ? (if_pc[IDX_W+1:2] ^ ghr) : if_pc[IDX_W+1:2];
        pred_taken = cnt_tbl[pred_idx][1];
    end

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        cnt_cur = cnt_tbl[ex_pred_idx];
        cnt_nxt = cnt_cur;
        if (branch_taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
        end
    end

    // Counter table: whole table reloads on reset, which beats a coincident update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_tbl[i] <= CNT_RST;
            end
        end else if (upd) begin
            cnt_tbl[ex_pred_idx] <= cnt_nxt;
        end
    end

    // Non-speculative global history, shifted only by resolved branches; held at 0 for bimodal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if ((GSHARE != 0) && upd) begin
            ghr <= {ghr[IDX_W-2:0], branch_taken};
        end
    end

`ifdef BPU_PERF_EN
    // Event counters for resolved branches and mispredictions; wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (upd) begin
            perf_branches <= perf_branches + 32'd1;
            perf_mispred  <= perf_mispred + {31'd0, mispredict};
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a bimodal instance and a gshare
// instance share all inputs; expected values are hand-computed per step.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic        ex_pred_taken;
    logic [5:0]  ex_pred_idx;
    logic        alu_out0;

    logic        pred_taken, pred_taken_g;
    logic [5:0]  pred_idx, pred_idx_g;
    logic        is_branch, is_branch_g;
    logic        is_jalr, is_jalr_g;
    logic [1:0]  inst_type, inst_type_g;
    logic        branch_taken, branch_taken_g;
    logic        mispredict, mispredict_g;
    logic [5:0]  ghr, ghr_g;
`ifdef BPU_PERF_EN
    logic [31:0] perf_branches, perf_mispred;
    logic [31:0] perf_branches_g, perf_mispred_g;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.IDX_W(6), .GSHARE(0), .CNT_INIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_idx(pred_idx),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pred_taken(ex_pred_taken),
        .ex_pred_idx(ex_pred_idx), .alu_out0(alu_out0),
        .is_branch(is_branch), .is_jalr(is_jalr), .inst_type(inst_type),
        .branch_taken(branch_taken), .mispredict(mispredict),
`ifdef BPU_PERF_EN
        .perf_branches(perf_branches), .perf_mispred(perf_mispred),
`endif
        .ghr(ghr)
    );

    branch_predict_unit #(.IDX_W(6), .GSHARE(1), .CNT_INIT(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken_g), .pred_idx(pred_idx_g),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pred_taken(ex_pred_taken),
        .ex_pred_idx(ex_pred_idx), .alu_out0(alu_out0),
        .is_branch(is_branch_g), .is_jalr(is_jalr_g), .inst_type(inst_type_g),
        .branch_taken(branch_taken_g), .mispredict(mispredict_g),
`ifdef BPU_PERF_EN
        .perf_branches(perf_branches_g), .perf_mispred(perf_mispred_g),
`endif
        .ghr(ghr_g)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 32'h40; ex_valid = 1'b0; ex_opcode = 5'b0;
        ex_pred_taken = 1'b0; ex_pred_idx = 6'd0; alu_out0 = 1'b0;
        step(); step();

        // Reset state and decode
        rst_n = 1'b1; ex_opcode = 5'b11000; alu_out0 = 1'b1; #1;
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_idx", {26'd0, pred_idx}, 32'd16);
        chk("rst_ghr", {26'd0, ghr}, 32'd0);
        chk("rst_ghr_g", {26'd0, ghr_g}, 32'd0);
        chk("dec_is_branch", {31'd0, is_branch}, 32'd1);
        chk("dec_br_type", {30'd0, inst_type}, 32'd2);
        chk("dec_br_taken", {31'd0, branch_taken}, 32'd1);
        chk("dec_mp_invalid", {31'd0, mispredict}, 32'd0);
        ex_opcode = 5'b11001; #1;
        chk("dec_is_jalr", {31'd0, is_jalr}, 32'd1);
        chk("dec_jalr_type", {30'd0, inst_type}, 32'd1);
        chk("dec_jalr_taken", {31'd0, branch_taken}, 32'd0);
        chk("dec_jalr_notbr", {31'd0, is_branch}, 32'd0);
        ex_valid = 1'b1; ex_pred_idx = 6'd16; ex_pred_taken = 1'b1; #1;
        chk("jalr_no_mp", {31'd0, mispredict}, 32'd0);
        step();
        chk("jalr_no_upd", {31'd0, pred_taken}, 32'd0);
        ex_opcode = 5'b00100; #1;
        chk("dec_other_type", {30'd0, inst_type}, 32'd0);

        // Saturation at idx 16 (counter starts at 1)
        ex_opcode = 5'b11000; ex_pred_taken = 1'b0; alu_out0 = 1'b1; #1;
        chk("mp_nt_pred_taken", {31'd0, mispredict}, 32'd1);
        repeat (4) step();
        chk("sat_hi_pred", {31'd0, pred_taken}, 32'd1);
        ex_pred_taken = 1'b1; #1;
        chk("no_mp_match", {31'd0, mispredict}, 32'd0);
        alu_out0 = 1'b0; #1;
        chk("mp_t_pred_nt", {31'd0, mispredict}, 32'd1);
        step();
        chk("sat_dec1_pred", {31'd0, pred_taken}, 32'd1);
        repeat (2) step();
        chk("sat_dec3_pred", {31'd0, pred_taken}, 32'd0);
        repeat (5) step();
        chk("sat_lo_pred", {31'd0, pred_taken}, 32'd0);
        alu_out0 = 1'b1; step();
        chk("floor_inc1", {31'd0, pred_taken}, 32'd0);
        step();
        chk("floor_inc2", {31'd0, pred_taken}, 32'd1);

        // ex_valid gating at idx 5
        ex_valid = 1'b0; ex_pred_idx = 6'd5; ex_pred_taken = 1'b0; #1;
        chk("mp_gated", {31'd0, mispredict}, 32'd0);
        step();
        if_pc = 32'h14; #1;
        chk("gated_no_upd", {31'd0, pred_taken}, 32'd0);
        ex_valid = 1'b1; step();
        chk("valid_upd", {31'd0, pred_taken}, 32'd1);

        // Reset overrides a coincident update and discards history
        rst_n = 1'b0; step();
        rst_n = 1'b1; ex_valid = 1'b0; #1;
        chk("rst_ovr_idx5", {31'd0, pred_taken}, 32'd0);
        chk("rst_ghr_g_mid", {26'd0, ghr_g}, 32'd0);
        if_pc = 32'h40; #1;
        chk("rst_idx16", {31'd0, pred_taken}, 32'd0);

        // Same-cycle lookup and update of idx 16 (1 -> 2)
        ex_valid = 1'b1; ex_pred_idx = 6'd16; alu_out0 = 1'b1; #1;
        chk("same_cyc_old", {31'd0, pred_taken}, 32'd0);
        step();
        ex_valid = 1'b0; #1;
        chk("same_cyc_new", {31'd0, pred_taken}, 32'd1);

        // Gshare history T,N,T
        rst_n = 1'b0; step(); rst_n = 1'b1;
        ex_valid = 1'b1; ex_pred_idx = 6'd0; alu_out0 = 1'b1; step();
        chk("ghr_T", {26'd0, ghr_g}, 32'd1);
        alu_out0 = 1'b0; step();
        chk("ghr_TN", {26'd0, ghr_g}, 32'd2);
        alu_out0 = 1'b1; step();
        chk("ghr_TNT", {26'd0, ghr_g}, 32'd5);
        ex_valid = 1'b0; step();
        chk("ghr_hold", {26'd0, ghr_g}, 32'd5);
        if_pc = 32'h40; #1;
        chk("gshare_idx", {26'd0, pred_idx_g}, 32'd21);
        chk("bimodal_idx", {26'd0, pred_idx}, 32'd16);
        chk("bimodal_ghr", {26'd0, ghr}, 32'd0);

`ifdef BPU_PERF_EN
        rst_n = 1'b0; step(); rst_n = 1'b1;
        ex_opcode = 5'b11000; ex_pred_idx = 6'd16; alu_out0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ex_valid = 1'b1;
            ex_pred_taken = !(i == 2 || i == 5 || i == 8);
            step();
        end
        ex_valid = 1'b0; #1;
        chk("perf_branches", perf_branches, 32'd10);
        chk("perf_mispred", perf_mispred, 32'd3);
        ex_valid = 1'b1; ex_opcode = 5'b11001; step();
        chk("perf_jalr_hold", perf_branches, 32'd10);
        ex_opcode = 5'b11000; rst_n = 1'b0; step();
        rst_n = 1'b1; ex_valid = 1'b0; #1;
        chk("perf_br_rst", perf_branches, 32'd0);
        chk("perf_mp_rst", perf_mispred, 32'd0);
        chk("perf_tbl_rst", {31'd0, pred_taken}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
